// File: rtl/spike_monitor.sv
// Spike-event monitor: per-window spike rate, timestamped event FIFO (first-word-fall-through),
// sticky overflow flag. Define SPIKE_MON_PEAK_EN to build per-window peak-of-state tracking.
module spike_monitor #(
    parameter int WINDOW = 256,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            spike,
    input  logic [7:0]      state,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [TS_W-1:0] evt_time,
    output logic [7:0]      rate,
    output logic            rate_valid,
    output logic            overflow,
    output logic [7:0]      peak
);

    localparam int              WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    function automatic logic [7:0] sat_inc8(input logic [7:0] a, input logic b);
        logic [8:0] s;
        s = {1'b0, a} + {8'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [TS_W-1:0]  r_ts;
    logic [WIN_W-1:0] r_win;
    logic [7:0]       r_spk_cnt;
    logic [7:0]       r_rate;
    logic             r_rate_vld;

    logic [TS_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_evt_valid;
    logic [TS_W-1:0]  r_evt_time;
    logic             r_overflow;

    logic             w_win_end;
    logic             w_pop;
    logic             w_full;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W:0]   w_cnt_after_pop;
    logic [PTR_W:0]   w_count_nxt;
    logic [TS_W-1:0]  w_head_nxt;

    assign w_win_end       = (r_win == WIN_LAST);
    assign w_pop           = r_evt_valid & evt_ready;
    assign w_full          = (r_count == FULL_CNT);
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign w_wr_en         = spike & (~w_full | w_pop);
    assign w_rd_ptr_nxt    = r_rd_ptr + PTR_W'(w_pop);
    assign w_cnt_after_pop = r_count - (PTR_W + 1)'(w_pop);
    assign w_count_nxt     = w_cnt_after_pop + (PTR_W + 1)'(w_wr_en);
    assign w_head_nxt      = (w_cnt_after_pop == '0) ? r_ts : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts  <= '0;
            r_win <= '0;
        end else begin
            r_ts  <= r_ts + 1'b1;
            r_win <= w_win_end ? '0 : r_win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spk_cnt  <= '0;
            r_rate     <= '0;
            r_rate_vld <= 1'b0;
        end else if (w_win_end) begin
            r_rate     <= sat_inc8(r_spk_cnt, spike);
            r_spk_cnt  <= '0;
            r_rate_vld <= 1'b1;
        end else begin
            r_spk_cnt  <= sat_inc8(r_spk_cnt, spike);
            r_rate_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_ts;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_evt_valid <= 1'b0;
            r_evt_time  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_evt_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_evt_time <= w_head_nxt;
            end
            if (spike & ~w_wr_en) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef SPIKE_MON_PEAK_EN
    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [7:0] r_run_max;
    logic [7:0] r_peak;
    logic [7:0] w_max_in;

    // The final cycle's state is folded in before the window result is captured.
    assign w_max_in = max8(r_run_max, state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_max <= '0;
            r_peak    <= '0;
        end else if (w_win_end) begin
            r_peak    <= w_max_in;
            r_run_max <= '0;
        end else begin
            r_run_max <= w_max_in;
        end
    end

    assign peak = r_peak;
`else
    logic w_unused_state;
    assign w_unused_state = ^state;
    assign peak           = '0;
`endif

    assign evt_valid  = r_evt_valid;
    assign evt_time   = r_evt_time;
    assign rate       = r_rate;
    assign rate_valid = r_rate_vld;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_spike_monitor.sv
// Self-checking bench for spike_monitor: vector table for FIFO corner cases, scoreboard queue
// for event timestamps, reference model for window rate/peak.
module tb_spike_monitor;
    localparam int WINDOW = 256;
    localparam int DEPTH  = 4;
    localparam int TS_W   = 12;
`ifdef SPIKE_MON_PEAK_EN
    localparam int PEAK_ON = 1;
`else
    localparam int PEAK_ON = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            spike = 1'b0;
    logic [7:0]      state = 8'd0;
    logic            evt_ready = 1'b0;
    logic            evt_valid;
    logic [TS_W-1:0] evt_time;
    logic [7:0]      rate;
    logic            rate_valid;
    logic            overflow;
    logic [7:0]      peak;

    spike_monitor #(.WINDOW(WINDOW), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst_n(rst_n), .spike(spike), .state(state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_time(evt_time),
        .rate(rate), .rate_valid(rate_valid), .overflow(overflow), .peak(peak)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        bit rst;
        bit sp;
        bit rd;
        bit ev;
        int et;
        bit ov;
    } vec_t;

    vec_t tbl[$];
    int   q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   m_cnt = 0;
    int   m_max = 0;
    int   m_rate = 0;
    int   m_peak = 0;
    bit   m_rv = 1'b0;
    bit   m_ovf = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void add(input int n, input bit r, input bit s, input bit d,
                                input bit ev, input int et, input bit ov);
        tbl.push_back('{n, r, s, d, ev, et, ov});
    endfunction

    function automatic logic [7:0] ramp(input int c);
        return (c <= 200) ? 8'(c) : 8'(400 - c);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_evt_valid"}, evt_valid, 0);
        chk({tag, "_evt_time"}, evt_time, 0);
        chk({tag, "_rate"}, rate, 0);
        chk({tag, "_rate_valid"}, rate_valid, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_peak"}, peak, 0);
    endtask

    // mid=1 asserts reset between clock edges and checks outputs before the next edge.
    task automatic do_reset(input bit mid);
        if (mid) begin
            @(posedge clk);
            #2;
        end else begin
            @(negedge clk);
        end
        rst_n = 1'b0;
        spike = 1'b1;
        #1;
        chk_all_zero(mid ? "rst_async" : "rst");
        repeat (2) @(negedge clk);
        chk("rst_spike_ignored_valid", evt_valid, 0);
        chk("rst_spike_ignored_ovf", overflow, 0);
        spike = 1'b0;
        evt_ready = 1'b0;
        state = 8'd0;
        rst_n = 1'b1;
        q.delete();
        cyc = 0; m_cnt = 0; m_max = 0; m_rate = 0; m_peak = 0; m_rv = 0; m_ovf = 0;
    endtask

    // Drive one cycle from a falling edge, update the model across the rising edge, check at the next falling edge.
    task automatic apply(input bit sp, input bit rd, input logic [7:0] st);
        spike = sp;
        evt_ready = rd;
        state = st;
        if (rd && q.size() != 0) void'(q.pop_front());
        if (sp) begin
            if (q.size() < DEPTH) q.push_back(cyc % (1 << TS_W));
            else m_ovf = 1'b1;
        end
        m_cnt += int'(sp);
        if (int'(st) > m_max) m_max = int'(st);
        @(posedge clk);
        cyc++;
        if (cyc % WINDOW == 0) begin
            m_rv = 1'b1;
            m_rate = (m_cnt > 255) ? 255 : m_cnt;
            m_peak = PEAK_ON ? m_max : 0;
            m_cnt = 0;
            m_max = 0;
        end else begin
            m_rv = 1'b0;
        end
        @(negedge clk);
        chk("sb_evt_valid", evt_valid, (q.size() != 0) ? 1 : 0);
        if (q.size() != 0 && evt_valid) chk("sb_evt_time", evt_time, q[0]);
        chk("sb_overflow", overflow, m_ovf);
        chk("sb_rate_valid", rate_valid, m_rv);
        chk("sb_rate", rate, m_rate);
        chk("sb_peak", peak, m_peak);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Three spikes queued while stalled, then drained in order.
        add(3, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 3, 0);
        add(6, 0, 0, 0, 1, 3, 0);
        add(1, 0, 1, 0, 1, 3, 0);
        add(6, 0, 0, 0, 1, 3, 0);
        add(1, 0, 1, 0, 1, 3, 0);
        add(1, 0, 0, 1, 1, 10, 0);
        add(1, 0, 0, 1, 1, 17, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(2, 0, 0, 1, 0, 0, 0);
        // Fill to full, then push+pop while full: no drop.
        add(1, 1, 1, 0, 1, 0, 0);
        add(3, 0, 1, 0, 1, 0, 0);
        add(1, 0, 1, 1, 1, 1, 0);
        add(1, 0, 1, 1, 1, 2, 0);
        add(1, 0, 0, 1, 1, 3, 0);
        add(1, 0, 0, 1, 1, 4, 0);
        add(1, 0, 0, 1, 1, 5, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        // Five spikes while stalled: fifth dropped, overflow sticks.
        add(1, 0, 1, 0, 1, 10, 0);
        add(3, 0, 1, 0, 1, 10, 0);
        add(1, 0, 1, 0, 1, 10, 1);
        add(3, 0, 0, 0, 1, 10, 1);
        add(1, 0, 0, 1, 1, 11, 1);
        add(1, 0, 0, 1, 1, 12, 1);
        add(1, 0, 0, 1, 1, 13, 1);
        add(2, 0, 0, 1, 0, 0, 1);

        do_reset(0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset(0);
            for (int k = 0; k < tbl[i].n; k++) begin
                apply(tbl[i].sp, tbl[i].rd, 8'd0);
                chk($sformatf("tbl%0d_valid", i), evt_valid, tbl[i].ev);
                if (tbl[i].ev) chk($sformatf("tbl%0d_time", i), evt_time, tbl[i].et);
                chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ov);
            end
        end

        // Overflow stays set across a window boundary; then queue three events mid-window.
        while (cyc < 300) apply(cyc % 3 == 0, 1'b1, 8'd0);
        chk("ovf_sticky", overflow, 1);
        repeat (2) apply(1'b0, 1'b1, 8'd0);
        repeat (3) apply(1'b1, 1'b0, 8'd0);
        repeat (5) apply(1'b0, 1'b0, 8'd0);
        chk("pre_async_valid", evt_valid, 1);
        do_reset(1);

        // Fresh window after async reset: sparse spikes incl. final cycle, ramped state.
        while (cyc < 260) begin
            apply(cyc % 3 == 0, 1'b1, ramp(cyc));
            if (cyc == 255) chk("win1_no_early_pulse", rate_valid, 0);
            if (cyc == 256) begin
                chk("win1_rate_valid", rate_valid, 1);
                chk("win1_rate", rate, 86);
                chk("win1_peak", peak, PEAK_ON ? 200 : 0);
            end
        end

        // Continuous spikes saturate the rate.
        do_reset(0);
        while (cyc < 520) begin
            apply(1'b1, 1'b1, 8'd0);
            if (cyc == 256 || cyc == 512) begin
                chk("sat_rate_valid", rate_valid, 1);
                chk("sat_rate", rate, 255);
            end
        end

        // Timestamp wraps from 4095 to 0.
        while (cyc < 4100) begin
            apply(cyc >= 4094 && cyc <= 4097, 1'b1, 8'd0);
            if (cyc == 4096) chk("ts_pre_wrap", evt_time, 4095);
            if (cyc == 4097) chk("ts_wrap", evt_time, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
